universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//  - Parametrised universal shift register: hold, shift right/left, parallel load, clear, optional rotate.
//  - Serial in/out at both ends, full parallel output.
//  - Shift counter flags each completed WIDTH-bit frame, for use as a SIPO/PISO serial-link front end.
// PARAMETERS
//  WIDTH      4   register width in bits; legal range WIDTH >= 2
//  RESET_VAL  0   value loaded into the register on reset and on CLEAR (WIDTH bits)
//  localparam CNT_W = $clog2(WIDTH)   width of shift_cnt
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst         in   1        reset, synchronous, active-high; highest priority
//  en          in   1        operation enable; 0 = hold all state
//  mode        in   3        operation select (see BEHAVIOUR)
//  sin_r       in   1        serial input entering the MSB on shift right
//  sin_l       in   1        serial input entering the LSB on shift left
//  pin         in   WIDTH    parallel load data
//  pout        out  WIDTH    register contents q
//  sout_r      out  1        q[0], the bit leaving on shift right (combinational from q)
//  sout_l      out  1        q[WIDTH-1], the bit leaving on shift left (combinational from q)
//  shift_cnt   out  CNT_W    shifts/rotates since last reset/load/clear, modulo WIDTH
//  frame_done  out  1        registered one-cycle pulse after every WIDTH-th shift/rotate
// BEHAVIOUR
//  - Reset (rst=1 at posedge): q=RESET_VAL, shift_cnt=0, frame_done=0. Overrides en and mode.
//    Mid-frame reset discards partial frame progress.
//  - en=0: q and shift_cnt hold; frame_done=0. mode, pin and serial inputs are ignored.
//  - en=1, mode decoding (effective at the next posedge, latency 1 cycle):
//    000 HOLD   q holds, shift_cnt holds
//    001 SHR    q <= {sin_r, q[WIDTH-1:1]}; counts
//    010 SHL    q <= {q[WIDTH-2:0], sin_l}; counts
//    011 LOAD   q <= pin; shift_cnt <= 0
//    100 ROTR   see CONFIGURATION
//    101 ROTL   see CONFIGURATION
//    110 CLEAR  q <= RESET_VAL; shift_cnt <= 0
//    111 HOLD   same as 000
//  - Counting ops (SHR, SHL, enabled rotates):
//    - shift_cnt < WIDTH-1: shift_cnt increments, frame_done <= 0.
//    - shift_cnt == WIDTH-1: shift_cnt <= 0, frame_done <= 1 for exactly one cycle.
//  - frame_done <= 0 on every cycle that is not the WIDTH-th counting op
//    (including HOLD, LOAD, CLEAR, en=0 and reset).
//  - Back-to-back frames with continuous shifting produce frame_done every WIDTH cycles, no gap cycles.
//  - SHR and SHL may be mixed within one frame; each counts as a single shift.
//  - sout_r/sout_l reflect the current q; the sampled output bit is valid before the shifting edge.
// CONFIGURATION
//  - Macro USR_ROTATE_EN.
//    - Defined: ROTR q <= {q[0], q[WIDTH-1:1]}; ROTL q <= {q[WIDTH-2:0], q[WIDTH-1]};
//      both count toward shift_cnt/frame_done.
//    - Undefined: modes 100 and 101 behave as HOLD; q and shift_cnt are unchanged, frame_done=0.
//  - Ports and mode width are identical in both builds.
// TESTING (WIDTH=4, RESET_VAL=0 unless stated)
//  1 rst 1 cycle; then en=1, mode=001, sin_r=1,0,1,1 on four edges
//    -> pout 1000,0100,1010,1101; shift_cnt 1,2,3,0; frame_done=1 only in the cycle after the 4th edge.
//  2 LOAD pin=1011; then mode=010, sin_l=0 -> sout_l=1 before the edge, pout=0110 after, shift_cnt=1.
//  3 LOAD 1001; mode=100 one edge
//    -> with USR_ROTATE_EN pout=1100, shift_cnt=1; without it pout=1001, shift_cnt=0.
//  4 Two SHR edges, then rst=1 for one edge -> pout=0000, shift_cnt=0, frame_done=0;
//    frame_done then requires four further shifts.
//  5 Three shifts (shift_cnt=3), then LOAD 0110 -> pout=0110, shift_cnt=0, frame_done stays 0;
//    en=0 with mode=001 holds pout=0110.
//  6 RESET_VAL=4'b1010: shift to 0001, then mode=110 -> pout=1010, shift_cnt=0; mode=111 holds.

Source files
------------

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right/left, parallel load, clear and frame counting.
// Optional rotate modes (100/101) are enabled by defining USR_ROTATE_EN.
module universal_shift_register #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_next_q;
    logic             w_count;
    logic             w_cnt_clr;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Unlisted modes (000, 111 and, without rotate support, 100/101) fall through to hold.
    always_comb begin
        w_next_q  = r_q;
        w_count   = 1'b0;
        w_cnt_clr = 1'b0;
        case (mode)
            MODE_SHR: begin
                w_next_q = {sin_r, r_q[WIDTH-1:1]};
                w_count  = 1'b1;
            end
            MODE_SHL: begin
                w_next_q = {r_q[WIDTH-2:0], sin_l};
                w_count  = 1'b1;
            end
            MODE_LOAD: begin
                w_next_q  = pin;
                w_cnt_clr = 1'b1;
            end
`ifdef USR_ROTATE_EN
            MODE_ROTR: begin
                w_next_q = {r_q[0], r_q[WIDTH-1:1]};
                w_count  = 1'b1;
            end
            MODE_ROTL: begin
                w_next_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_count  = 1'b1;
            end
`endif
            MODE_CLEAR: begin
                w_next_q  = RESET_VAL;
                w_cnt_clr = 1'b1;
            end
            default: begin
                w_next_q = r_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= RESET_VAL;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_frame_done <= 1'b0;
        end else begin
            r_q <= w_next_q;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_count) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
            // Pulse only on the op that completes a WIDTH-shift frame.
            r_frame_done <= w_count && w_last;
        end
    end

    assign pout       = r_q;
    assign sout_r     = r_q[0];
    assign sout_l     = r_q[WIDTH-1];
    assign shift_cnt  = r_cnt;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: vector table through a scoreboard queue,
// plus a hand sequence on a second instance with a non-zero reset value.
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [3:0] pin, pout;
    logic       sout_r, sout_l, frame_done;
    logic [1:0] shift_cnt;

    logic       rst6, en6, sin_r6, sin_l6;
    logic [2:0] mode6;
    logic [3:0] pin6, pout6;
    logic       sout_r6, sout_l6, frame_done6;
    logic [1:0] shift_cnt6;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pin(pin), .pout(pout), .sout_r(sout_r), .sout_l(sout_l),
        .shift_cnt(shift_cnt), .frame_done(frame_done)
    );

    universal_shift_register #(.WIDTH(4), .RESET_VAL(4'b1010)) dut6 (
        .clk(clk), .rst(rst6), .en(en6), .mode(mode6), .sin_r(sin_r6), .sin_l(sin_l6),
        .pin(pin6), .pout(pout6), .sout_r(sout_r6), .sout_l(sout_l6),
        .shift_cnt(shift_cnt6), .frame_done(frame_done6)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic       sr;
        logic       sl;
        logic [3:0] pin;
        logic [3:0] e_pout;
        logic [1:0] e_cnt;
        logic       e_fd;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] pout;
        logic [1:0] cnt;
        logic       fd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, input logic e, input logic [2:0] m, input logic sr,
                       input logic sl, input logic [3:0] p, input logic [3:0] ep,
                       input logic [1:0] ec, input logic efd);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sr = sr; v.sl = sl; v.pin = p;
        v.e_pout = ep; v.e_cnt = ec; v.e_fd = efd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic step6(input logic r, input logic [2:0] m, input logic [3:0] ep,
                         input logic [1:0] ec, input int idx);
        @(negedge clk);
        rst6 = r; en6 = 1'b1; mode6 = m; sin_r6 = 1'b0;
        @(posedge clk); #1;
        chk("rv_pout", idx, 32'(pout6), 32'(ep));
        chk("rv_cnt", idx, 32'(shift_cnt6), 32'(ec));
        chk("rv_fd", idx, 32'(frame_done6), 32'(0));
    endtask

    initial begin
        rst = 1; en = 0; mode = 0; sin_r = 0; sin_l = 0; pin = 0;
        rst6 = 1; en6 = 0; mode6 = 0; sin_r6 = 0; sin_l6 = 0; pin6 = 0;

        //   rst en mode    sr sl pin      pout     cnt fd
        add(1, 0, 3'b000, 0, 0, 4'h0, 4'b0000, 0, 0);  // reset
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0);  // SHR frame
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0100, 2, 0);
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1010, 3, 0);
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1101, 0, 1);
        add(0, 1, 3'b000, 0, 0, 4'h0, 4'b1101, 0, 0);  // hold clears pulse
        add(0, 1, 3'b011, 0, 0, 4'hB, 4'b1011, 0, 0);  // load, sout_l=1
        add(0, 1, 3'b010, 0, 0, 4'h0, 4'b0110, 1, 0);  // SHL
        add(0, 1, 3'b011, 0, 0, 4'h9, 4'b1001, 0, 0);
`ifdef USR_ROTATE_EN
        add(0, 1, 3'b100, 1, 1, 4'h0, 4'b1100, 1, 0);  // ROTR
        add(0, 1, 3'b101, 0, 0, 4'h0, 4'b1001, 2, 0);  // ROTL
`else
        add(0, 1, 3'b100, 1, 1, 4'h0, 4'b1001, 0, 0);
        add(0, 1, 3'b101, 0, 0, 4'h0, 4'b1001, 0, 0);
`endif
        add(0, 1, 3'b011, 0, 0, 4'h0, 4'b0000, 0, 0);
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1000, 1, 0);
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1100, 2, 0);
        add(1, 1, 3'b001, 1, 0, 4'h0, 4'b0000, 0, 0);  // mid-frame reset
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 1, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 2, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 3, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 0, 1);
        add(0, 1, 3'b010, 0, 1, 4'h0, 4'b0001, 1, 0);  // mixed directions
        add(0, 1, 3'b010, 0, 1, 4'h0, 4'b0011, 2, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0001, 3, 0);
        add(0, 1, 3'b011, 0, 0, 4'h6, 4'b0110, 0, 0);  // load at cnt=3
        add(0, 0, 3'b001, 1, 0, 4'hF, 4'b0110, 0, 0);  // en=0 holds
        add(0, 0, 3'b010, 0, 1, 4'hF, 4'b0110, 0, 0);
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1011, 1, 0);  // back-to-back frames
        add(0, 1, 3'b001, 1, 0, 4'h0, 4'b1101, 2, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0110, 3, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0011, 0, 1);
        add(0, 1, 3'b010, 0, 1, 4'h0, 4'b0111, 1, 0);
        add(0, 1, 3'b010, 0, 0, 4'h0, 4'b1110, 2, 0);
        add(0, 1, 3'b010, 0, 0, 4'h0, 4'b1100, 3, 0);
        add(0, 1, 3'b010, 0, 1, 4'h0, 4'b1001, 0, 1);
        add(0, 1, 3'b110, 1, 1, 4'hF, 4'b0000, 0, 0);  // clear
        add(0, 1, 3'b011, 0, 0, 4'h5, 4'b0101, 0, 0);
        add(0, 1, 3'b111, 1, 1, 4'hA, 4'b0101, 0, 0);  // 111 holds
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0010, 1, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0001, 2, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 3, 0);
        add(0, 1, 3'b001, 0, 0, 4'h0, 4'b0000, 0, 1);
        add(0, 0, 3'b001, 0, 0, 4'h0, 4'b0000, 0, 0);  // en=0 drops pulse

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            exp_t got;
            @(negedge clk);
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            sin_r = vecs[i].sr; sin_l = vecs[i].sl; pin = vecs[i].pin;
            e.idx = i; e.pout = vecs[i].e_pout; e.cnt = vecs[i].e_cnt; e.fd = vecs[i].e_fd;
            sb.push_back(e);
            @(posedge clk); #1;
            got = sb.pop_front();
            chk("pout", got.idx, 32'(pout), 32'(got.pout));
            chk("shift_cnt", got.idx, 32'(shift_cnt), 32'(got.cnt));
            chk("frame_done", got.idx, 32'(frame_done), 32'(got.fd));
            chk("sout_r", got.idx, 32'(sout_r), 32'(got.pout[0]));
            chk("sout_l", got.idx, 32'(sout_l), 32'(got.pout[3]));
        end

        step6(1, 3'b000, 4'b1010, 0, 100);
        step6(0, 3'b001, 4'b0101, 1, 101);
        step6(0, 3'b001, 4'b0010, 2, 102);
        step6(0, 3'b001, 4'b0001, 3, 103);
        step6(0, 3'b110, 4'b1010, 0, 104);
        step6(0, 3'b111, 4'b1010, 0, 105);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
